// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator and the PWM capture block.
//   cap_state_e  capture FSM state (SEEK, ACTIVE, INACTIVE)
//   CNT_W_DEF    default width of the duty/period counters
//   TMO_CYC_DEF  default stuck-input timeout in clk cycles; this is longer
//                than the 2 ms maximum PWM period at 262.144 MHz
package pwm_pkg;

  localparam int CNT_W_DEF   = 24;
  localparam int TMO_CYC_DEF = 1048575;

  typedef enum logic [1:0] {
    SEEK,
    ACTIVE,
    INACTIVE
  } cap_state_e;

endpackage

// File: rtl/pwm_glitch_filter.sv
// pwm_glitch_filter: synchronises an asynchronous input and removes short glitches.
// The output follows the input only after FILT_LEN consecutive synchronised
// samples that differ from the current output. The delay from an input edge
// to the output edge is SYNC_STAGES+FILT_LEN clk cycles.
//   clk   system clock
//   rsn   asynchronous reset, active high; clears the synchroniser and output
//   din   asynchronous input
//   dout  filtered level, in the clk domain
module pwm_glitch_filter #(
  parameter int SYNC_STAGES = 2,  // minimum 2
  parameter int FILT_LEN    = 4   // 1..15
) (
  input  logic clk,
  input  logic rsn,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             run_cnt;
  logic                   smp;

  assign smp = sync_q[SYNC_STAGES-1];

  // NOTE: flops are written with <= so each stage samples the old value of
  // the stage before it, which is what makes this a shift chain.
  always_ff @(posedge clk or posedge rsn) begin
    if (rsn) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // run_cnt counts consecutive samples that disagree with dout. One sample
  // that agrees with dout restarts the count, so pulses shorter than
  // FILT_LEN samples never reach the output.
  always_ff @(posedge clk or posedge rsn) begin
    if (rsn) begin
      run_cnt <= '0;
      dout    <= 1'b0;
    end else if (smp == dout) begin
      run_cnt <= '0;
    end else if (run_cnt == 4'(FILT_LEN - 1)) begin
      run_cnt <= '0;
      dout    <= smp;
    end else begin
      run_cnt <= run_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures an external PWM waveform in the clk domain.
// Once per period it publishes the active time and the period as clk-cycle
// counts. An input with no edges for TMO_CYC cycles is reported as stuck.
//   clk         system clock, 262.144 MHz
//   rsn         asynchronous reset, active high
//   en          capture enable; low returns to SEEK and clears the counters
//   pwm_i       asynchronous PWM input
//   PWM_POL     0 = active level high, 1 = active level low
//   duty_cnt    active cycles in the last complete period
//   period_cnt  cycles between the last two active-start edges
//   meas_vld    one-cycle pulse when the outputs below are updated
//   ovf         a counter saturated during the published period
//   stuck_act   the input was held at the active level until the timeout
//   stuck_idle  the input was held at the idle level until the timeout
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int TMO_CYC     = TMO_CYC_DEF
) (
  input  logic             clk,
  input  logic             rsn,
  input  logic             en,
  input  logic             pwm_i,
  input  logic             PWM_POL,
  output logic [CNT_W-1:0] duty_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_vld,
  output logic             ovf,
  output logic             stuck_act,
  output logic             stuck_idle
);

  localparam int               TMO_W    = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_FULL = TMO_W'(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             filt, filt_q, pol_q;
  logic             fedge, act, start_e, end_e, pol_chg, tmo_hit;
  logic             pub, stuck;
  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] act_cnt_q, act_cnt_d, per_cnt_q, per_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  pwm_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt (
    .clk (clk),
    .rsn (rsn),
    .din (pwm_i),
    .dout(filt)
  );

  // Edges are taken on the filtered level itself, so a change of PWM_POL
  // flips act without creating an edge. The polarity change is caught
  // separately by comparing PWM_POL with its registered copy.
  assign fedge   = filt ^ filt_q;
  assign act     = filt ^ PWM_POL;
  assign start_e = fedge & act;
  assign end_e   = fedge & ~act;
  assign pol_chg = PWM_POL ^ pol_q;
  // The timeout fires on the cycle tmo_q would step to TMO_CYC. Once tmo_q
  // holds at TMO_CYC there are no further pulses until an edge clears it.
  // An edge in the same cycle suppresses the timeout.
  assign tmo_hit = ~fedge & (tmo_q == TMO_LAST);

  // NOTE: every variable gets a default before the case, so no path through
  // this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    act_cnt_d = act_cnt_q;
    per_cnt_d = per_cnt_q;
    tmo_d     = tmo_q;
    pub       = 1'b0;
    stuck     = 1'b0;
    if (!en || pol_chg) begin
      state_d   = SEEK;
      act_cnt_d = '0;
      per_cnt_d = '0;
      tmo_d     = '0;
    end else begin
      if (fedge)                 tmo_d = '0;
      else if (tmo_q != TMO_FULL) tmo_d = tmo_q + TMO_W'(1);

      unique case (state_q)
        SEEK: begin
          if (start_e) begin
            state_d   = ACTIVE;
            act_cnt_d = CNT_ONE;
            per_cnt_d = CNT_ONE;
          end
        end
        ACTIVE: begin
          per_cnt_d = sat_inc(per_cnt_q);
          if (end_e) state_d   = INACTIVE;
          else       act_cnt_d = sat_inc(act_cnt_q);
        end
        INACTIVE: begin
          if (start_e) begin
            pub       = 1'b1;
            state_d   = ACTIVE;
            act_cnt_d = CNT_ONE;
            per_cnt_d = CNT_ONE;
          end else begin
            per_cnt_d = sat_inc(per_cnt_q);
          end
        end
        default: state_d = SEEK;
      endcase

      if (tmo_hit) begin
        stuck     = 1'b1;
        state_d   = SEEK;
        act_cnt_d = '0;
        per_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rsn) begin
    if (rsn) begin
      filt_q    <= 1'b0;
      pol_q     <= 1'b0;
      state_q   <= SEEK;
      act_cnt_q <= '0;
      per_cnt_q <= '0;
      tmo_q     <= '0;
    end else begin
      filt_q    <= filt;
      pol_q     <= PWM_POL;
      state_q   <= state_d;
      act_cnt_q <= act_cnt_d;
      per_cnt_q <= per_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  // The outputs hold between publishes. A normal publish and a timeout never
  // happen in the same cycle: one needs an edge and the other needs none.
  always_ff @(posedge clk or posedge rsn) begin
    if (rsn) begin
      duty_cnt   <= '0;
      period_cnt <= '0;
      meas_vld   <= 1'b0;
      ovf        <= 1'b0;
      stuck_act  <= 1'b0;
      stuck_idle <= 1'b0;
    end else begin
      meas_vld <= pub | stuck;
      if (pub) begin
        duty_cnt   <= act_cnt_q;
        period_cnt <= per_cnt_q;
        ovf        <= (act_cnt_q == CNT_MAX) | (per_cnt_q == CNT_MAX);
        stuck_act  <= 1'b0;
        stuck_idle <= 1'b0;
      end else if (stuck) begin
        duty_cnt   <= '0;
        period_cnt <= '0;
        ovf        <= 1'b0;
        stuck_act  <= act;
        stuck_idle <= ~act;
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Receive-side counterpart of the PWM generator. Samples an external PWM waveform, typically a loopback of the generator output or a PWM from another device, in the system clock domain. Once per PWM period it publishes the measured active-time and period as raw clk-cycle counts. It flags stuck-level (0 %/100 % duty) inputs via a timeout, and sits on the control bus next to the generator for closed-loop checking and external PWM decode.

Parameters:
CNT_W, 24, width of the duty/period counters and outputs; counters saturate at 2^CNT_W-1.
SYNC_STAGES, 2, number of synchronizer flops on pwm_i (minimum 2).
FILT_LEN, 4, consecutive equal synchronized samples required to accept a new level (1..15).
TMO_CYC, 1048575, clk cycles without an accepted edge before a stuck condition is declared; exceeds the 2 ms maximum period at 262.144 MHz.

Ports:
clk  in  1  system clock, 262.144 MHz
rsn  in  1  reset, asynchronous, active-high
en  in  1  capture enable; low forces SEEK and clears counters
pwm_i  in  1  asynchronous PWM input
PWM_POL  in  1  0 = active level high (idle low), 1 = active level low (idle high)
duty_cnt  out  CNT_W  clk cycles the input was active in the last complete period
period_cnt  out  CNT_W  clk cycles between the last two active-start edges
meas_vld  out  1  one-cycle pulse when duty_cnt/period_cnt/flags are updated
ovf  out  1  a counter saturated during the published period
stuck_act  out  1  input held at the active level for TMO_CYC cycles
stuck_idle  out  1  input held at the idle level for TMO_CYC cycles

Behaviour:
- Reset: all outputs 0, state SEEK, counters 0, synchronizer and filter outputs 0.
- Input path: SYNC_STAGES flops, then the filter. The filtered level flips only after FILT_LEN identical samples differing from the current filtered level.
- Latency from a pwm_i edge to the filtered edge is SYNC_STAGES+FILT_LEN cycles.
- act = filtered XOR PWM_POL. Active-start edge = act 0->1; active-end edge = act 1->0.
- FSM states:
  - SEEK: wait for an active-start edge, then go to ACTIVE with act_cnt=1, per_cnt=1.
  - ACTIVE: act_cnt++ and per_cnt++ each cycle. On an active-end edge, go to INACTIVE.
  - INACTIVE: per_cnt++. On an active-start edge, publish and go to ACTIVE with act_cnt=1, per_cnt=1.
- Publish: the registered outputs update on the cycle after the edge, meas_vld=1 for exactly that cycle. Outputs are duty_cnt=act_cnt, period_cnt=per_cnt, ovf=(either counter saturated), stuck_act=0, stuck_idle=0.
- The first publish follows the second active-start edge after leaving SEEK; no partial period is ever published.
- Saturation: counters hold at all-ones and do not wrap; the sticky per-period ovf clears on every restart.
- Timeout: tmo_cnt clears on any filtered edge and increments otherwise (also counts in SEEK). When it reaches TMO_CYC:
  - publish duty_cnt=0, period_cnt=0, ovf=0.
  - set stuck_act=act and stuck_idle=!act, pulse meas_vld.
  - go to SEEK and hold tmo_cnt; no further pulses until an edge occurs.
  - stuck flags persist until the next normal publish or reset.
- PWM_POL change (registered compare) or en low: go to SEEK, clear act_cnt/per_cnt/tmo_cnt, no publish; outputs hold their last values.
- Simultaneous timeout and edge in the same cycle: the edge wins and the timeout is suppressed.
- Async reset mid-period: immediate clear, no meas_vld pulse.

Decomposition:
- pwm_pkg: the capture FSM state enum (SEEK, ACTIVE, INACTIVE) and the default CNT_W/TMO_CYC constants, shared with the generator.
- Sub-module pwm_glitch_filter: synchronizer plus FILT_LEN filter, output is the filtered level; reusable for other async inputs.

Test Plan:
- POL=0, pwm_i high 100 / low 300 cycles repeating: the first meas_vld follows the 2nd rising edge + SYNC_STAGES+FILT_LEN+1 cycles. Then duty_cnt=100, period_cnt=400, ovf=0, one pulse every 400 cycles.
- Same waveform plus a 3-cycle high glitch mid-low-phase (FILT_LEN=4): glitch ignored, outputs unchanged at 100/400.
- POL=1, pwm_i low 150 / high 250 cycles repeating: duty_cnt=150, period_cnt=400.
- TMO_CYC=1000, pwm_i held low after locking: one meas_vld with duty=0, period=0, stuck_idle=1, no repeat pulses. Then resume the 100/400 wave: stuck_idle clears on the next publish.
- CNT_W=8, 100/300 waveform: period_cnt=255, duty_cnt=100, ovf=1. Then 50/200: ovf=0.
- Assert rsn mid-ACTIVE, then release: all outputs 0, no meas_vld until two new active-start edges; toggling PWM_POL mid-period produces no publish.
